// File: rtl/spla_pkg.sv
// ============================================================================
// Module : spla_pkg
// Brief  : Shared type definitions for the frequency meter block.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package spla_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ARMED     = 2'd1,
        ST_TIMED_OUT = 2'd2
    } fm_state_t;

endpackage

`default_nettype wire

// File: rtl/sync2.sv
// ============================================================================
// Module : sync2
// Brief  : Two-flop single-bit synchroniser with asynchronous active-low reset.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module sync2 (
    input  logic clock,
    input  logic reset_n,
    input  logic i_d,
    output logic o_q
);

    logic [1:0] r_sync;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_sync <= 2'b00;
        end else begin
            r_sync <= {r_sync[0], i_d};
        end
    end

    assign o_q = r_sync[1];

endmodule

`default_nettype wire

// File: rtl/freq_meter.sv
// ============================================================================
// Module : freq_meter
// Brief  : Measures the period of an asynchronous square wave, flags range and
//          timeout. Define FREQ_METER_MINMAX_EN to add min/max tracking.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module freq_meter
    import spla_pkg::*;
#(
    parameter int W        = 24,
    parameter int EXPECTED = 12000000,
    parameter int TOL      = 120000,
    parameter int TIMEOUT  = 15000000
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         sig_i,
    output logic [W-1:0] period_o,
    output logic         valid_o,
    output logic         in_range_o,
    output logic         timeout_o,
    output logic         ok_led_o
`ifdef FREQ_METER_MINMAX_EN
    ,
    input  logic         clear_i,
    output logic [W-1:0] min_o,
    output logic [W-1:0] max_o
`endif
);

    // Window bounds carry one extra bit so EXPECTED+TOL cannot wrap.
    localparam logic [W:0]   c_lo      = (EXPECTED > TOL) ? (W+1)'(EXPECTED - TOL) : '0;
    localparam logic [W:0]   c_hi      = (W+1)'(EXPECTED + TOL);
    localparam logic [W-1:0] c_timeout = W'(TIMEOUT);
    localparam logic [W-1:0] c_cnt_max = '1;
    localparam logic [W-1:0] c_cnt_one = W'(1);

    logic         w_sync;
    logic         r_prev;
    logic         w_rise;
    fm_state_t    r_state;
    fm_state_t    w_state_nxt;
    logic [W-1:0] r_cnt;
    logic [W-1:0] w_cnt_nxt;
    logic [W-1:0] w_cnt_inc;
    logic         w_meas;
    logic         w_to_set;
    logic         w_to_clr;
    logic         w_in_win;
    logic [W-1:0] r_period;
    logic         r_valid;
    logic         r_in_range;
    logic         r_timeout;

    sync2 u_sync2 (
        .clock   (clock),
        .reset_n (reset_n),
        .i_d     (sig_i),
        .o_q     (w_sync)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_prev <= 1'b0;
        end else begin
            r_prev <= w_sync;
        end
    end

    assign w_rise    = w_sync & ~r_prev;
    assign w_cnt_inc = (r_cnt == c_cnt_max) ? r_cnt : r_cnt + c_cnt_one;
    assign w_in_win  = ({1'b0, r_cnt} >= c_lo) && ({1'b0, r_cnt} <= c_hi);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // An edge in the same cycle as the timeout count takes priority.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_meas      = 1'b0;
        w_to_set    = 1'b0;
        w_to_clr    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_rise) begin
                    w_cnt_nxt   = c_cnt_one;
                    w_state_nxt = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (w_rise) begin
                    w_meas    = 1'b1;
                    w_cnt_nxt = c_cnt_one;
                end else if (r_cnt == c_timeout) begin
                    w_to_set    = 1'b1;
                    w_state_nxt = ST_TIMED_OUT;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            ST_TIMED_OUT: begin
                if (w_rise) begin
                    w_to_clr    = 1'b1;
                    w_cnt_nxt   = c_cnt_one;
                    w_state_nxt = ST_ARMED;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_period   <= '0;
            r_valid    <= 1'b0;
            r_in_range <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            r_valid <= w_meas;
            if (w_meas) begin
                r_period   <= r_cnt;
                r_in_range <= w_in_win;
            end
            if (w_to_set) begin
                r_timeout  <= 1'b1;
                r_in_range <= 1'b0;
            end
            if (w_to_clr) begin
                r_timeout <= 1'b0;
            end
        end
    end

    assign period_o   = r_period;
    assign valid_o    = r_valid;
    assign in_range_o = r_in_range;
    assign timeout_o  = r_timeout;
    assign ok_led_o   = r_in_range & ~r_timeout;

`ifdef FREQ_METER_MINMAX_EN
    logic [W-1:0] r_min;
    logic [W-1:0] r_max;
    logic         r_have_first;

    // A clear coinciding with a measurement treats that measurement as the first.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_min        <= '0;
            r_max        <= '0;
            r_have_first <= 1'b0;
        end else if (w_meas) begin
            r_have_first <= 1'b1;
            if (!r_have_first || clear_i) begin
                r_min <= r_cnt;
                r_max <= r_cnt;
            end else begin
                if (r_cnt < r_min) r_min <= r_cnt;
                if (r_cnt > r_max) r_max <= r_cnt;
            end
        end else if (clear_i) begin
            r_have_first <= 1'b0;
        end
    end

    assign min_o = r_min;
    assign max_o = r_max;
`endif

endmodule

`default_nettype wire

// File: tb/tb_freq_meter.sv
// ============================================================================
// Module : tb_freq_meter
// Brief  : Directed self-checking bench for freq_meter (W=8, EXPECTED=100,
//          TOL=2, TIMEOUT=150); min/max checks when FREQ_METER_MINMAX_EN is set.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_freq_meter;

    logic       clock;
    logic       reset_n;
    logic       sig_i;
    logic [7:0] period_o;
    logic       valid_o;
    logic       in_range_o;
    logic       timeout_o;
    logic       ok_led_o;
    logic       clear_i;
`ifdef FREQ_METER_MINMAX_EN
    logic [7:0] min_o;
    logic [7:0] max_o;
`endif

    int total = 0;
    int bad   = 0;
    int n_valid = 0;
    int run = 0;
    int maxrun = 0;
    int cap_period = 0;
    bit cap_in = 0;
    bit cap_ok = 0;
    bit tout_seen = 0;

    freq_meter #(
        .W        (8),
        .EXPECTED (100),
        .TOL      (2),
        .TIMEOUT  (150)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .sig_i      (sig_i),
        .period_o   (period_o),
        .valid_o    (valid_o),
        .in_range_o (in_range_o),
        .timeout_o  (timeout_o),
        .ok_led_o   (ok_led_o)
`ifdef FREQ_METER_MINMAX_EN
        ,
        .clear_i    (clear_i),
        .min_o      (min_o),
        .max_o      (max_o)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Records each valid pulse and the outputs seen alongside it.
    always @(negedge clock) begin
        if (valid_o === 1'b1) begin
            n_valid    = n_valid + 1;
            cap_period = int'(period_o);
            cap_in     = in_range_o;
            cap_ok     = ok_led_o;
            run        = run + 1;
            if (run > maxrun) maxrun = run;
        end else begin
            run = 0;
        end
        if (timeout_o === 1'b1) tout_seen = 1'b1;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    task automatic wave(input int hi, input int lo);
        sig_i = 1'b1;
        repeat (hi) @(posedge clock);
        #1;
        sig_i = 1'b0;
        repeat (lo) @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        sig_i   = 1'b0;
        clear_i = 1'b0;
        repeat (3) @(posedge clock);
        #1 reset_n = 1'b1;
        repeat (2) @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        sig_i   = 1'b0;
        clear_i = 1'b0;
        repeat (2) @(negedge clock);
        total++; if (period_o !== 8'd0)    begin bad++; $display("FAIL reset_period: got %0d expected 0", period_o); end
        total++; if (valid_o !== 1'b0)     begin bad++; $display("FAIL reset_valid: got %b expected 0", valid_o); end
        total++; if (in_range_o !== 1'b0)  begin bad++; $display("FAIL reset_in_range: got %b expected 0", in_range_o); end
        total++; if (timeout_o !== 1'b0)   begin bad++; $display("FAIL reset_timeout: got %b expected 0", timeout_o); end
        total++; if (ok_led_o !== 1'b0)    begin bad++; $display("FAIL reset_ok_led: got %b expected 0", ok_led_o); end
`ifdef FREQ_METER_MINMAX_EN
        total++; if (min_o !== 8'd0)       begin bad++; $display("FAIL reset_min: got %0d expected 0", min_o); end
        total++; if (max_o !== 8'd0)       begin bad++; $display("FAIL reset_max: got %0d expected 0", max_o); end
`endif
        @(posedge clock);
        #1 reset_n = 1'b1;
        repeat (2) @(posedge clock);
        #1;
    endtask

    task automatic test_nominal();
        int n0;
        do_reset();
        n0 = n_valid;
        maxrun = 0;
        wave(50, 50);
        total++; if (n_valid != n0) begin bad++; $display("FAIL nominal_arm_no_valid: got %0d pulses expected 0", n_valid - n0); end
        repeat (3) wave(50, 50);
        repeat (5) @(posedge clock);
        #1;
        total++; if (n_valid - n0 != 3)  begin bad++; $display("FAIL nominal_pulse_count: got %0d expected 3", n_valid - n0); end
        total++; if (cap_period != 100)  begin bad++; $display("FAIL nominal_period: got %0d expected 100", cap_period); end
        total++; if (cap_in !== 1'b1)    begin bad++; $display("FAIL nominal_in_range: got %b expected 1", cap_in); end
        total++; if (cap_ok !== 1'b1)    begin bad++; $display("FAIL nominal_ok_led: got %b expected 1", cap_ok); end
        total++; if (maxrun != 1)        begin bad++; $display("FAIL nominal_valid_width: got %0d cycles expected 1", maxrun); end
    endtask

    task automatic test_range();
        int lows [4] = '{47, 48, 52, 53};
        bit exp_in [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        int n0;
        do_reset();
        wave(50, 50);
        wave(50, lows[0]);
        for (int i = 0; i < 4; i++) begin
            n0 = n_valid;
            wave(50, (i < 3) ? lows[i+1] : 50);
            total++; if (n_valid != n0 + 1)      begin bad++; $display("FAIL range_valid_%0d: got %0d pulses expected 1", i, n_valid - n0); end
            total++; if (cap_period != 50 + lows[i]) begin bad++; $display("FAIL range_period_%0d: got %0d expected %0d", i, cap_period, 50 + lows[i]); end
            total++; if (cap_in !== exp_in[i])    begin bad++; $display("FAIL range_in_range_%0d: got %b expected %b", i, cap_in, exp_in[i]); end
            total++; if (cap_ok !== exp_in[i])    begin bad++; $display("FAIL range_ok_led_%0d: got %b expected %b", i, cap_ok, exp_in[i]); end
        end
    endtask

    task automatic test_timeout();
        int n0;
        do_reset();
        wave(50, 50);
        wave(50, 50);
        sig_i = 1'b1;
        repeat (147) @(posedge clock);
        @(negedge clock);
        total++; if (timeout_o !== 1'b0) begin bad++; $display("FAIL timeout_early: got %b expected 0", timeout_o); end
        total++; if (ok_led_o !== 1'b1)  begin bad++; $display("FAIL timeout_ok_before: got %b expected 1", ok_led_o); end
        repeat (9) @(posedge clock);
        @(negedge clock);
        total++; if (timeout_o !== 1'b1)  begin bad++; $display("FAIL timeout_set: got %b expected 1", timeout_o); end
        total++; if (ok_led_o !== 1'b0)   begin bad++; $display("FAIL timeout_ok_led: got %b expected 0", ok_led_o); end
        total++; if (in_range_o !== 1'b0) begin bad++; $display("FAIL timeout_in_range: got %b expected 0", in_range_o); end
        total++; if (period_o !== 8'd100) begin bad++; $display("FAIL timeout_period_hold: got %0d expected 100", period_o); end
        @(posedge clock);
        #1 sig_i = 1'b0;
        repeat (5) @(posedge clock);
        #1;
        n0 = n_valid;
        wave(50, 50);
        total++; if (timeout_o !== 1'b0) begin bad++; $display("FAIL timeout_clear: got %b expected 0", timeout_o); end
        total++; if (n_valid != n0)      begin bad++; $display("FAIL timeout_rearm_no_valid: got %0d pulses expected 0", n_valid - n0); end
        wave(50, 50);
        total++; if (n_valid != n0 + 1)  begin bad++; $display("FAIL timeout_resume_valid: got %0d pulses expected 1", n_valid - n0); end
        total++; if (cap_period != 100)  begin bad++; $display("FAIL timeout_resume_period: got %0d expected 100", cap_period); end
    endtask

    task automatic test_edge_on_timeout();
        int n0;
        do_reset();
        wave(50, 50);
        tout_seen = 1'b0;
        wave(75, 75);
        n0 = n_valid;
        wave(50, 50);
        total++; if (n_valid != n0 + 1)  begin bad++; $display("FAIL edge_tie_valid: got %0d pulses expected 1", n_valid - n0); end
        total++; if (cap_period != 150)  begin bad++; $display("FAIL edge_tie_period: got %0d expected 150", cap_period); end
        total++; if (cap_in !== 1'b0)    begin bad++; $display("FAIL edge_tie_in_range: got %b expected 0", cap_in); end
        total++; if (tout_seen !== 1'b0) begin bad++; $display("FAIL edge_tie_timeout: got %b expected 0", tout_seen); end
    endtask

    task automatic test_reset_mid();
        int n0;
        do_reset();
        wave(50, 50);
        wave(50, 50);
        sig_i = 1'b1;
        repeat (50) @(posedge clock);
        #1 sig_i = 1'b0;
        repeat (10) @(posedge clock);
        #1 reset_n = 1'b0;
        #2;
        total++; if (period_o !== 8'd0)   begin bad++; $display("FAIL midreset_period: got %0d expected 0", period_o); end
        total++; if (valid_o !== 1'b0)    begin bad++; $display("FAIL midreset_valid: got %b expected 0", valid_o); end
        total++; if (in_range_o !== 1'b0) begin bad++; $display("FAIL midreset_in_range: got %b expected 0", in_range_o); end
        total++; if (timeout_o !== 1'b0)  begin bad++; $display("FAIL midreset_timeout: got %b expected 0", timeout_o); end
        total++; if (ok_led_o !== 1'b0)   begin bad++; $display("FAIL midreset_ok_led: got %b expected 0", ok_led_o); end
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;
        repeat (5) @(posedge clock);
        #1;
        n0 = n_valid;
        wave(50, 50);
        total++; if (n_valid != n0)     begin bad++; $display("FAIL midreset_arm_no_valid: got %0d pulses expected 0", n_valid - n0); end
        wave(50, 50);
        total++; if (n_valid != n0 + 1) begin bad++; $display("FAIL midreset_resume_valid: got %0d pulses expected 1", n_valid - n0); end
        total++; if (cap_period != 100) begin bad++; $display("FAIL midreset_period_after: got %0d expected 100", cap_period); end
    endtask

`ifdef FREQ_METER_MINMAX_EN
    task automatic test_minmax();
        do_reset();
        wave(50, 50);
        wave(50, 46);
        wave(50, 54);
        sig_i = 1'b1;
        repeat (50) @(posedge clock);
        @(negedge clock);
        total++; if (min_o !== 8'd96)  begin bad++; $display("FAIL minmax_min: got %0d expected 96", min_o); end
        total++; if (max_o !== 8'd104) begin bad++; $display("FAIL minmax_max: got %0d expected 104", max_o); end
        @(posedge clock);
        #1;
        sig_i   = 1'b0;
        clear_i = 1'b1;
        @(posedge clock);
        #1 clear_i = 1'b0;
        repeat (47) @(posedge clock);
        #1;
        wave(50, 50);
        total++; if (cap_period != 99) begin bad++; $display("FAIL minmax_clear_period: got %0d expected 99", cap_period); end
        total++; if (min_o !== 8'd99)  begin bad++; $display("FAIL minmax_clear_min: got %0d expected 99", min_o); end
        total++; if (max_o !== 8'd99)  begin bad++; $display("FAIL minmax_clear_max: got %0d expected 99", max_o); end
    endtask
`endif

    initial begin
        reset_n = 1'b0;
        sig_i   = 1'b0;
        clear_i = 1'b0;
        test_reset();
        test_nominal();
        test_range();
        test_timeout();
        test_edge_on_timeout();
        test_reset_mid();
`ifdef FREQ_METER_MINMAX_EN
        test_minmax();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
